// File: rtl/fifo_arb_pkg.sv
// Shared constants for the dual-core FIFO arbiter: opcodes, FSM states, core IDs.
// Pure declarations; no logic.
package fifo_arb_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: pointer holder wins a tie, a lone requester always wins.
// Combinational, zero latency; no backpressure of its own.
module rr_arb2
  import fifo_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  always_comb begin
    gnt_o = req_i;
    ptr_o = ptr_i;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_i == CORE1) ? 2'b10 : 2'b01;
    end
    if (gnt_o != 2'b00) begin
      ptr_o = gnt_o[0] ? CORE1 : CORE0;
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Shares one FIFO between two cores: round-robin grant, command in cycle T+1, ack in T+2.
// One transaction per 3 cycles; requests arriving while busy simply wait on req.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int NUM_ENTRIES  = 2,
  parameter int OPCODE_WIDTH = 2,
  parameter int EXTRA_BIT    = 1,
  parameter int LINE_WIDTH   = DATA_WIDTH + OPCODE_WIDTH + EXTRA_BIT,
  parameter int COUNT_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req,
  input  logic                   c0_op,
  input  logic [DATA_WIDTH-1:0]  c0_wdata,
  output logic                   c0_ack,
  output logic                   c0_err,
  output logic [DATA_WIDTH-1:0]  c0_rdata,
  input  logic                   c1_req,
  input  logic                   c1_op,
  input  logic [DATA_WIDTH-1:0]  c1_wdata,
  output logic                   c1_ack,
  output logic                   c1_err,
  output logic [DATA_WIDTH-1:0]  c1_rdata,
  output logic [LINE_WIDTH-1:0]  fifo_vector,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic [COUNT_WIDTH-1:0] fifo_count
);

  state_e                 state_q;
  logic                   ptr_q;
  logic                   ptr_d;
  logic                   gid_q;
  logic                   op_q;
  logic                   legal_q;
  logic [LINE_WIDTH-1:0]  vec_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [1:0]             ack_q;
  logic [1:0]             err_q;
  logic [DATA_WIDTH-1:0]  rdata_q [2];

  logic [1:0]              req;
  logic [1:0]              gnt;
  logic                    gid_d;
  logic                    op_d;
  logic                    legal_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [OPCODE_WIDTH-1:0] opc_d;
  logic [DATA_WIDTH-1:0]   pay_d;
  logic [LINE_WIDTH-1:0]   cmd_d;

  assign req = {c1_req, c0_req};

  rr_arb2 u_rr_arb2 (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .ptr_o (ptr_d)
  );

  // Legality is judged against our own count so the FIFO never sees an illegal command.
  always_comb begin
    gid_d   = gnt[1];
    op_d    = gid_d ? c1_op : c0_op;
    wdata_d = gid_d ? c1_wdata : c0_wdata;
    legal_d = op_d ? (count_q != COUNT_WIDTH'(NUM_ENTRIES)) : (count_q != '0);
    opc_d   = op_d ? OPCODE_WIDTH'(OP_WRITE) : OPCODE_WIDTH'(OP_READ);
    pay_d   = op_d ? wdata_d : {DATA_WIDTH{1'b0}};
    cmd_d   = '0;
    if (legal_d) begin
      cmd_d = {opc_d, pay_d, EXTRA_BIT'(gid_d)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= CORE0;
      gid_q      <= CORE0;
      op_q       <= 1'b0;
      legal_q    <= 1'b0;
      vec_q      <= '0;
      count_q    <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req != 2'b00) begin
            gid_q   <= gid_d;
            op_q    <= op_d;
            legal_q <= legal_d;
            vec_q   <= cmd_d;
            ptr_q   <= ptr_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          vec_q <= '0;
          if (legal_q) begin
            if (op_q) begin
              count_q <= count_q + COUNT_WIDTH'(1);
            end else begin
              count_q <= count_q - COUNT_WIDTH'(1);
              rdata_q[gid_q] <= fifo_rdata;
            end
          end
          ack_q[gid_q] <= 1'b1;
          err_q[gid_q] <= ~legal_q;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          ack_q   <= '0;
          err_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          vec_q   <= '0;
          ack_q   <= '0;
          err_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_vector = vec_q;
  assign fifo_count  = count_q;
  assign c0_ack      = ack_q[0];
  assign c1_ack      = ack_q[1];
  assign c0_err      = err_q[0];
  assign c1_err      = err_q[1];
  assign c0_rdata    = rdata_q[0];
  assign c1_rdata    = rdata_q[1];

endmodule
